muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Sequences the iterative M-extension unit (shift-add multiply, restoring divide) for the 5-stage RV32IM pipeline.
//  Accepts one MUL/DIV/REM op from Execute and stalls IF/ID/EX while it runs.
//  Handles the RISC-V divide-by-zero and overflow cases without iterating, and delivers one result per op.
//  Sits beside the ALU in EX; its result is muxed into ALUResultE on done_o.
// PARAMETERS
//  XLEN   32                 operand/result width
//  CNT_W  $clog2(XLEN)+1     iteration counter width
// PORTS
//  clk       in   1     clock, rising edge
//  rst       in   1     reset, asynchronous, active-low
//  start_i   in   1     valid M-ext op present in EX this cycle
//  funct3_i  in   3     M-ext funct3 (MUL..REMU)
//  op_a_i    in   XLEN  rs1 value (multiplicand/dividend)
//  op_b_i    in   XLEN  rs2 value (multiplier/divisor)
//  flush_i   in   1     kill the op in EX (branch/jump redirect)
//  stall_o   out  1     hold IF/ID/EX pipeline registers
//  busy_o    out  1     FSM not in IDLE
//  done_o    out  1     one-cycle pulse; result_o valid
//  result_o  out  XLEN  registered result; holds until next done_o
// BEHAVIOUR
//  Reset (asynchronous, any state): state=IDLE, counter=0, done_o=0, busy_o=0, result_o=0; stall_o=0 while start_i=0.
//  FSM states and transitions:
//   IDLE  -> DONE if start_i & ~flush_i and the op is a fast case.
//   IDLE  -> PREP if start_i & ~flush_i otherwise. Operands and funct3 are captured on this edge.
//   PREP  -> RUN. Takes absolute values of signed operands, records result sign, loads counter=XLEN-1.
//   RUN   -> FIXUP when counter==0. One core step per cycle; counter decrements each cycle.
//   FIXUP -> DONE. Conditionally negates, selects hi/lo or quotient/remainder, registers result_o.
//   DONE  -> IDLE. done_o=1 this cycle only.
//  stall_o = (IDLE & start_i & ~flush_i) | PREP | RUN | FIXUP. It is combinational so the freeze starts in the start cycle.
//  stall_o=0 in DONE, so EX advances on the edge that ends DONE. start_i seen in DONE is ignored (it is the old instruction).
//  Latency, normal op: start in cycle 0 -> done_o in cycle XLEN+3 (35 for XLEN=32). Throughput: 1 op per XLEN+4 cycles.
//  Latency, fast case: done_o in cycle 1.
//  Fast cases:
//   DIV/DIVU by 0: quotient = all ones. REM/REMU by 0: result = op_a.
//   DIV with 0x80000000 / -1: result = 0x80000000. REM with the same operands: result = 0.
//  Result rules:
//   MUL = low XLEN of the product.
//   MULH = high XLEN, signed x signed. MULHSU = high XLEN, signed x unsigned. MULHU = high XLEN, unsigned x unsigned.
//   DIV/DIVU truncate toward zero. Remainder takes the sign of the dividend.
//   Signed ops use magnitude arithmetic with a 2's-complement fixup in FIXUP. All internal arithmetic is unsigned, 2*XLEN wide.
//  flush_i in PREP/RUN/FIXUP: next state IDLE, no done_o, result_o unchanged, stall_o drops in the same cycle.
//  flush_i in DONE: done_o still pulses (the instruction has already completed).
//  start_i & flush_i in IDLE: op ignored, stall_o=0.
//  Mid-operation reset: abort immediately to the reset values; no partial result is exposed.
//  funct3 values outside M-ext: not produced by the decoder; they are treated as MUL.
// STRUCTURE
//  muldiv_pkg holds:
//   typedef enum logic [2:0] md_op_e {MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU}
//   typedef enum md_state_e {IDLE,PREP,RUN,FIXUP,DONE}
//   XLEN localparam
//  Sub-module muldiv_core: the iterative datapath.
//   Inputs: load, step, is_div, abs operands.
//   Outputs: {hi,lo} accumulator, quotient, remainder.
//   Holds no FSM. This module owns all control and the fixup logic.
// TESTING
//  MUL 7 x 6 -> done_o in cycle 35, result_o=0x0000002A; stall_o high in cycles 0..34, low in 35.
//  MULH 0xFFFFFFFF x 0xFFFFFFFF (-1*-1) -> 0x00000000. MULHU with the same operands -> 0xFFFFFFFE. MULHSU -> 0xFFFFFFFF.
//  DIV -7 / 2 -> 0xFFFFFFFD (-3). REM -7 % 2 -> 0xFFFFFFFF (-1). DIVU 100 / 7 -> 14. REMU 100 % 7 -> 2.
//  DIVU x/0 with x=0x1234 -> done_o in cycle 1, result 0xFFFFFFFF.
//   REM 0x1234 % 0 -> 0x1234. DIV 0x80000000 / -1 -> 0x80000000. REM of the same -> 0.
//  Start DIV, assert flush_i in cycle 10 -> no done_o, stall_o=0 from cycle 10, result_o unchanged.
//   A new MUL 3 x 5 started in cycle 12 -> 15.
//  Deassert rst in cycle 20 of a MULHU -> outputs 0 asynchronously, FSM in IDLE.
//   After release, back-to-back MUL, DIV ops return correct results with no lost/duplicate done_o.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative M-extension multiply/divide unit.
package muldiv_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = $clog2(XLEN) + 1;

   typedef enum logic [2:0] {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU} md_op_e;
   typedef enum logic [2:0] {IDLE, PREP, RUN, FIXUP, DONE} md_state_e;

   function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic is_signed);
      return (is_signed && v[XLEN-1]) ? -v : v;
   endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative datapath: shift-add multiply and restoring divide on magnitudes, one step per cycle.
module muldiv_core
   import muldiv_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   input  logic              is_div,
   input  logic [XLEN-1:0]   abs_a,
   input  logic [XLEN-1:0]   abs_b,
   output logic [2*XLEN-1:0] acc,
   output logic [XLEN-1:0]   quotient,
   output logic [XLEN-1:0]   remainder
);

   // hi holds the partial product / running remainder, lo the multiplier / quotient bits.
   logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
   logic [XLEN:0]   add_sum, shl_rem, sub_diff, mul_hi;

   always_comb begin
      hi_d     = hi_q;
      lo_d     = lo_q;
      opnd_d   = opnd_q;
      add_sum  = {1'b0, hi_q} + {1'b0, opnd_q};
      shl_rem  = {hi_q, lo_q[XLEN-1]};
      sub_diff = shl_rem - {1'b0, opnd_q};
      mul_hi   = lo_q[0] ? add_sum : {1'b0, hi_q};
      if (load) begin
         hi_d   = '0;
         lo_d   = is_div ? abs_a : abs_b;
         opnd_d = is_div ? abs_b : abs_a;
      end else if (step) begin
         if (is_div) begin
            if (shl_rem >= {1'b0, opnd_q}) begin
               hi_d = sub_diff[XLEN-1:0];
               lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
               hi_d = shl_rem[XLEN-1:0];
               lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
         end else begin
            {hi_d, lo_d} = {mul_hi, lo_q[XLEN-1:1]};
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hi_q   <= '0;
         lo_q   <= '0;
         opnd_q <= '0;
      end else begin
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         opnd_q <= opnd_d;
      end
   end

   assign acc       = {hi_q, lo_q};
   assign quotient  = lo_q;
   assign remainder = hi_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// Control FSM for the M-extension unit: fast divide corner cases, sign handling, pipeline stall.
module muldiv_sequencer
   import muldiv_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] op_a_i,
   input  logic [XLEN-1:0] op_b_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam logic [2:0] StIdle  = IDLE;
   localparam logic [2:0] StPrep  = PREP;
   localparam logic [2:0] StRun   = RUN;
   localparam logic [2:0] StFixup = FIXUP;
   localparam logic [2:0] StDone  = DONE;

   localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

   logic [2:0]        state_q, state_d, op_q, op_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
   logic              neg_q, neg_d, neg_rem_q, neg_rem_d;
   logic              accept, div_zero, div_ovf, fast, in_op;
   logic              is_div, signed_a, signed_b;
   logic [XLEN-1:0]   fast_res, fixup_res, abs_a, abs_b, quotient, remainder;
   logic [2*XLEN-1:0] acc, prod;

   assign accept   = (state_q == StIdle) & start_i & ~flush_i;
   assign in_op    = (state_q == StPrep) | (state_q == StRun) | (state_q == StFixup);
   assign div_zero = funct3_i[2] & (op_b_i == '0);
   assign div_ovf  = ((funct3_i == DIV) | (funct3_i == REM)) & (op_a_i == MinNeg) & (op_b_i == '1);
   assign fast     = div_zero | div_ovf;
   // funct3[1] separates REM/REMU from DIV/DIVU.
   assign fast_res = div_ovf ? (funct3_i[1] ? '0 : MinNeg) : (funct3_i[1] ? op_a_i : '1);

   assign is_div   = op_q[2];
   assign signed_a = (op_q == MULH) | (op_q == MULHSU) | (op_q == DIV) | (op_q == REM);
   assign signed_b = (op_q == MULH) | (op_q == DIV) | (op_q == REM);
   assign abs_a    = abs_val(a_q, signed_a);
   assign abs_b    = abs_val(b_q, signed_b);
   assign prod     = neg_q ? -acc : acc;

   always_comb begin
      if (is_div) begin
         fixup_res = op_q[1] ? (neg_rem_q ? -remainder : remainder)
                             : (neg_q ? -quotient : quotient);
      end else begin
         fixup_res = (op_q == MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;
      case (state_q)
         StIdle: begin
            if (accept) begin
               if (fast) begin
                  state_d  = StDone;
                  result_d = fast_res;
               end else begin
                  state_d = StPrep;
                  op_d    = funct3_i;
                  a_d     = op_a_i;
                  b_d     = op_b_i;
               end
            end
         end
         StPrep: begin
            state_d   = StRun;
            cnt_d     = CNT_W'(XLEN - 1);
            neg_d     = (signed_a & a_q[XLEN-1]) ^ (signed_b & b_q[XLEN-1]);
            neg_rem_d = signed_a & a_q[XLEN-1];
         end
         StRun: begin
            if (cnt_q == '0) state_d = StFixup;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         StFixup: begin
            state_d  = StDone;
            result_d = fixup_res;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      // A completed op in DONE is not killed by a redirect.
      if (flush_i && in_op) begin
         state_d  = StIdle;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         result_q  <= result_d;
      end
   end

   muldiv_core u_core (
      .clk       (clk),
      .rst       (rst),
      .load      (state_q == StPrep),
      .step      (state_q == StRun),
      .is_div    (is_div),
      .abs_a     (abs_a),
      .abs_b     (abs_b),
      .acc       (acc),
      .quotient  (quotient),
      .remainder (remainder)
   );

   assign stall_o  = accept | (in_op & ~flush_i);
   assign busy_o   = (state_q != StIdle);
   assign done_o   = (state_q == StDone);
   assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: results, latency, stall window, flush and async reset.
module tb_muldiv_sequencer;

   localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1, F_MULHSU = 3'd2, F_MULHU = 3'd3;
   localparam logic [2:0] F_DIV = 3'd4, F_DIVU = 3'd5, F_REM = 3'd6, F_REMU = 3'd7;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, flush;
   logic [2:0]  funct3;
   logic [31:0] op_a, op_b, result;
   logic        stall, busy, done;
   int          n_cmp = 0;
   int          n_bad = 0;

   muldiv_sequencer dut (
      .clk      (clk),
      .rst      (rst),
      .start_i  (start),
      .funct3_i (funct3),
      .op_a_i   (op_a),
      .op_b_i   (op_b),
      .flush_i  (flush),
      .stall_o  (stall),
      .busy_o   (busy),
      .done_o   (done),
      .result_o (result)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // start is held high until done, as a stalled EX stage would; lat is the done cycle.
   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
      int   cyc       = 0;
      int   stall_cyc = 0;
      logic seen      = 1'b0;
      logic stall_end = 1'b1;
      @(posedge clk); #1;
      start = 1'b1; funct3 = f; op_a = a; op_b = b;
      while (!seen && cyc < 64) begin
         @(negedge clk);
         if (done) begin
            seen      = 1'b1;
            stall_end = stall;
         end else begin
            if (stall) stall_cyc++;
            @(posedge clk); #1;
            cyc++;
         end
      end
      check_eq({tag, "_done"}, {31'b0, seen}, 32'd1);
      check_eq({tag, "_lat"}, cyc, lat);
      check_eq({tag, "_stall_cycles"}, stall_cyc, lat);
      check_eq({tag, "_stall_in_done"}, {31'b0, stall_end}, 32'd0);
      check_eq(tag, result, exp);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
      #12;
      check_eq("rst_busy", {31'b0, busy}, 32'd0);
      check_eq("rst_done", {31'b0, done}, 32'd0);
      check_eq("rst_stall", {31'b0, stall}, 32'd0);
      check_eq("rst_result", result, 32'd0);
      rst = 1'b1;

      run_op("mul_7x6",   F_MUL,    32'd7,        32'd6,        32'h0000002A, 35);
      run_op("mulh_m1",   F_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 35);
      run_op("mulhu_max", F_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 35);
      run_op("mulhsu_m1", F_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 35);
      run_op("mul_wrap",  F_MUL,    32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 35);
      run_op("div_m7_2",  F_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 35);
      run_op("rem_m7_2",  F_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 35);
      run_op("divu_z",    F_DIVU,   32'h1234,     32'd0,        32'hFFFFFFFF, 1);
      run_op("rem_z",     F_REM,    32'h1234,     32'd0,        32'h00001234, 1);
      run_op("div_ovf",   F_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
      run_op("rem_ovf",   F_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
      run_op("divu_100",  F_DIVU,   32'd100,      32'd7,        32'd14,       35);
      run_op("remu_100",  F_REMU,   32'd100,      32'd7,        32'd2,        35);

      // start together with flush in IDLE is dropped
      @(posedge clk); #1;
      start = 1'b1; flush = 1'b1; funct3 = F_MUL; op_a = 32'd9; op_b = 32'd9;
      @(negedge clk);
      check_eq("idle_flush_stall", {31'b0, stall}, 32'd0);
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      @(negedge clk);
      check_eq("idle_flush_busy", {31'b0, busy}, 32'd0);

      // flush a DIV in cycle 10
      @(posedge clk); #1;
      start = 1'b1; funct3 = F_DIV; op_a = 32'd100; op_b = 32'd7;
      repeat (10) @(posedge clk);
      #1 flush = 1'b1;
      @(negedge clk);
      check_eq("flush_stall", {31'b0, stall}, 32'd0);
      check_eq("flush_done_c10", {31'b0, done}, 32'd0);
      @(posedge clk); #1;
      flush = 1'b0; start = 1'b0;
      @(negedge clk);
      check_eq("flush_busy", {31'b0, busy}, 32'd0);
      check_eq("flush_done_c11", {31'b0, done}, 32'd0);
      check_eq("flush_result_held", result, 32'd2);
      run_op("mul_3x5", F_MUL, 32'd3, 32'd5, 32'd15, 35);

      // asynchronous reset in cycle 20 of a MULHU
      @(posedge clk); #1;
      start = 1'b1; funct3 = F_MULHU; op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF;
      repeat (20) @(posedge clk);
      #3 rst = 1'b0; start = 1'b0;
      #1;
      check_eq("arst_busy", {31'b0, busy}, 32'd0);
      check_eq("arst_done", {31'b0, done}, 32'd0);
      check_eq("arst_stall", {31'b0, stall}, 32'd0);
      check_eq("arst_result", result, 32'd0);
      @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      check_eq("post_rst_busy", {31'b0, busy}, 32'd0);

      run_op("b2b_mul", F_MUL, 32'h00010000, 32'h00010001, 32'h00010000, 35);
      run_op("b2b_div", F_DIV, 32'd1000,     32'hFFFFFFF6, 32'hFFFFFF9C, 35);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check_eq("no_dup_done", {31'b0, done}, 32'd0);
      check_eq("final_result", result, 32'hFFFFFF9C);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
